// File: rtl/tm_master_reorder_if.sv
// Request-tag, NoC reply and in-order reply signals of the master-side reorder buffer.
// The slave modport is the reorder block; the master modport is its environment.
interface tm_master_reorder_if #(
  parameter int WIDTH_DATA       = 36,
  parameter int VC_ADDRESS_WIDTH = 2
);
  logic                        req_valid;
  logic [VC_ADDRESS_WIDTH-1:0] req_ret_vc;
  logic                        order_full;
  logic                        rx_valid;
  logic [VC_ADDRESS_WIDTH-1:0] rx_vc;
  logic [WIDTH_DATA-1:0]       rx_data;
  logic [3:0]                  rx_ready;
  logic                        out_valid;
  logic [WIDTH_DATA-1:0]       out_data;
  logic                        out_ready;
  logic [3:0]                  credit_ret;
  logic                        err_overflow;

  modport slave (
    input  req_valid, req_ret_vc, rx_valid, rx_vc, rx_data, out_ready,
    output order_full, rx_ready, out_valid, out_data, credit_ret, err_overflow
  );

  modport master (
    output req_valid, req_ret_vc, rx_valid, rx_vc, rx_data, out_ready,
    input  order_full, rx_ready, out_valid, out_data, credit_ret, err_overflow
  );
endinterface

// File: rtl/tm_master_reorder.sv
// Return-path reorder buffer: records the return VC of each issued request, buffers NoC
// replies per VC and releases them in request order with a one-cycle credit pulse.
module tm_master_reorder #(
  parameter int WIDTH_DATA       = 36,
  parameter int VC_ADDRESS_WIDTH = 2,
  parameter int ORDER_DEPTH      = 32,
  parameter int VC_BUF_DEPTH     = 8
) (
  input logic               clk,
  input logic               preset_full,
  tm_master_reorder_if.slave bus
);
  localparam int NUM_VC    = 4;
  localparam int ORD_PTR_W = $clog2(ORDER_DEPTH);
  localparam int VC_PTR_W  = $clog2(VC_BUF_DEPTH);

  localparam logic [ORD_PTR_W-1:0] ORD_PTR_ONE  = ORD_PTR_W'(1);
  localparam logic [ORD_PTR_W:0]   ORD_CNT_ONE  = (ORD_PTR_W + 1)'(1);
  localparam logic [ORD_PTR_W:0]   ORD_CNT_FULL = (ORD_PTR_W + 1)'(ORDER_DEPTH);
  localparam logic [VC_PTR_W-1:0]  VC_PTR_ONE   = VC_PTR_W'(1);
  localparam logic [VC_PTR_W:0]    VC_CNT_ONE   = (VC_PTR_W + 1)'(1);
  localparam logic [VC_PTR_W:0]    VC_CNT_FULL  = (VC_PTR_W + 1)'(VC_BUF_DEPTH);

  // Order-tag FIFO
  logic [VC_ADDRESS_WIDTH-1:0] ord_mem [ORDER_DEPTH];
  logic [ORD_PTR_W-1:0]        ord_wr_ptr, ord_rd_ptr;
  logic [ORD_PTR_W:0]          ord_count;

  // Per-VC reply FIFOs
  logic [WIDTH_DATA-1:0] vc_mem    [NUM_VC][VC_BUF_DEPTH];
  logic [VC_PTR_W-1:0]   vc_wr_ptr [NUM_VC];
  logic [VC_PTR_W-1:0]   vc_rd_ptr [NUM_VC];
  logic [VC_PTR_W:0]     vc_count  [NUM_VC];

  logic                        out_valid_q;
  logic [WIDTH_DATA-1:0]       out_data_q;
  logic [NUM_VC-1:0]           credit_q;
  logic                        err_q;

  logic [VC_ADDRESS_WIDTH-1:0] head_vc;
  logic                        ord_empty, ord_full;
  logic                        issue, ord_push, ord_drop, rx_drop;
  logic [NUM_VC-1:0]           vc_full, vc_nonempty, vc_push, vc_pop;

  assign head_vc   = ord_mem[ord_rd_ptr];
  assign ord_empty = (ord_count == '0);
  assign ord_full  = (ord_count == ORD_CNT_FULL);

  // Status comes from registered counts only, so rx_ready/order_full never see rx_valid/req_valid.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      vc_full[v]     = (vc_count[v] == VC_CNT_FULL);
      vc_nonempty[v] = (vc_count[v] != '0);
    end
  end

  assign issue = !ord_empty && vc_nonempty[head_vc] && (!out_valid_q || bus.out_ready);

  // A tag may enter a full order FIFO only when the head leaves in the same cycle.
  assign ord_push = bus.req_valid && (!ord_full || issue);
  assign ord_drop = bus.req_valid && ord_full && !issue;
  assign rx_drop  = bus.rx_valid && vc_full[bus.rx_vc];

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    vc_push = '0;
    vc_pop  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_push[v] = bus.rx_valid && (bus.rx_vc == VC_ADDRESS_WIDTH'(v)) && !vc_full[v];
      vc_pop[v]  = issue && (head_vc == VC_ADDRESS_WIDTH'(v));
    end
  end

  // NOTE: storage arrays carry no reset; emptiness is tracked by the reset counters alone.
  always_ff @(posedge clk) begin
    if (ord_push) ord_mem[ord_wr_ptr] <= bus.req_ret_vc;
    for (int v = 0; v < NUM_VC; v++) begin
      if (vc_push[v]) vc_mem[v][vc_wr_ptr[v]] <= bus.rx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge preset_full) begin
    if (preset_full) begin
      ord_wr_ptr  <= '0;
      ord_rd_ptr  <= '0;
      ord_count   <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        vc_wr_ptr[v] <= '0;
        vc_rd_ptr[v] <= '0;
        vc_count[v]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      credit_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (ord_push) ord_wr_ptr <= ord_wr_ptr + ORD_PTR_ONE;
      if (issue)    ord_rd_ptr <= ord_rd_ptr + ORD_PTR_ONE;
      case ({ord_push, issue})
        2'b10:   ord_count <= ord_count + ORD_CNT_ONE;
        2'b01:   ord_count <= ord_count - ORD_CNT_ONE;
        default: ord_count <= ord_count;
      endcase

      for (int v = 0; v < NUM_VC; v++) begin
        if (vc_push[v]) vc_wr_ptr[v] <= vc_wr_ptr[v] + VC_PTR_ONE;
        if (vc_pop[v])  vc_rd_ptr[v] <= vc_rd_ptr[v] + VC_PTR_ONE;
        case ({vc_push[v], vc_pop[v]})
          2'b10:   vc_count[v] <= vc_count[v] + VC_CNT_ONE;
          2'b01:   vc_count[v] <= vc_count[v] - VC_CNT_ONE;
          default: vc_count[v] <= vc_count[v];
        endcase
      end

      if (ord_drop || rx_drop) err_q <= 1'b1;

      credit_q <= issue ? (4'b0001 << head_vc) : 4'b0000;
      if (issue) begin
        out_valid_q <= 1'b1;
        out_data_q  <= vc_mem[head_vc][vc_rd_ptr[head_vc]];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.order_full   = ord_full;
  assign bus.rx_ready     = ~vc_full;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.credit_ret   = credit_q;
  assign bus.err_overflow = err_q;
endmodule
